// File: rtl/avalon_debounced_button_pio.sv
// Avalon-MM button/switch PIO: synchroniser, per-bit debounce, rise/fall edge capture (W1C), masked level irq.
// Read latency 1 cycle; pin-to-capture latency SYNC_STAGES+DEBOUNCE_CYCLES+1; slave never stalls (no waitrequest).
module avalon_debounced_button_pio #(
  parameter int WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] rise_evt, fall_evt, clr_mask, wr_dat;
  logic             wr_vld;
  logic             unused_wdata;

  assign raw          = sync_q[SYNC_STAGES-1];
  assign wr_vld       = chipselect & ~write_n;
  assign wr_dat       = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end

    // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (raw[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = raw[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    prev_d   = stable_q;
    rise_evt = stable_q & ~prev_q & rise_en_q;
    fall_evt = ~stable_q & prev_q & fall_en_q;
    clr_mask = (wr_vld && address == 3'd3) ? wr_dat : '0;
    // New events are OR-ed in after the clear so a colliding W1C never drops an edge.
    edge_cap_d = (edge_cap_q & ~clr_mask) | rise_evt | fall_evt;

    irq_mask_d = (wr_vld && address == 3'd2) ? wr_dat : irq_mask_q;
    fall_en_d  = (wr_vld && address == 3'd4) ? wr_dat : fall_en_q;
    rise_en_d  = (wr_vld && address == 3'd5) ? wr_dat : rise_en_q;

    readdata_d = '0;
    case (address)
      3'd0:    readdata_d[WIDTH-1:0] = stable_q;
      3'd1:    readdata_d[WIDTH-1:0] = raw;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4:    readdata_d[WIDTH-1:0] = fall_en_q;
      3'd5:    readdata_d[WIDTH-1:0] = rise_en_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q      <= '0;
      stable_q   <= IDLE_LEVEL;
      prev_q     <= IDLE_LEVEL;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_debounced_button_pio.sv
// Bench for avalon_debounced_button_pio: directed scenarios plus randomized traffic against a window-based reference model.
module tb_avalon_debounced_button_pio;
  localparam int W = 4;
  localparam int SYNC = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         irq;
  logic [W-1:0] in_port;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  avalon_debounced_button_pio #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port)
  );

  // Reference model: pipeline of raw samples, and a sliding window of the last DEB raw
  // samples; a stable bit flips only when the whole window disagrees with it.
  logic [W-1:0] m_sync0, m_sync1, m_stable, m_prev, m_ec, m_mask, m_rise, m_fall;
  logic [31:0]  m_rd;
  logic         m_irq;
  logic [W-1:0] m_win[$];

  task automatic m_reset();
    m_sync0 = '1; m_sync1 = '1; m_stable = '1; m_prev = '1;
    m_ec = '0; m_mask = '0; m_rise = '0; m_fall = '1;
    m_rd = '0; m_irq = 1'b0;
    m_win.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] nstable, rise, fall, clr, wd;
    logic [31:0]  rd;
    logic         wr, flip;
    if (!reset_n) begin
      m_reset();
      return;
    end
    m_win.push_back(m_sync1);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    nstable = m_stable;
    if (m_win.size() == DEB) begin
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) flip = 1'b0;
        if (flip) nstable[b] = ~m_stable[b];
      end
    end
    rise = m_stable & ~m_prev & m_rise;
    fall = ~m_stable & m_prev & m_fall;
    case (address)
      3'd0: rd = 32'(m_stable);
      3'd1: rd = 32'(m_sync1);
      3'd2: rd = 32'(m_mask);
      3'd3: rd = 32'(m_ec);
      3'd4: rd = 32'(m_fall);
      3'd5: rd = 32'(m_rise);
      default: rd = 32'h0;
    endcase
    wr  = chipselect && !write_n;
    wd  = writedata[W-1:0];
    clr = (wr && address == 3'd3) ? wd : '0;
    m_ec = (m_ec & ~clr) | rise | fall;
    if (wr && address == 3'd2) m_mask = wd;
    if (wr && address == 3'd4) m_fall = wd;
    if (wr && address == 3'd5) m_rise = wd;
    m_rd     = rd;
    m_prev   = m_stable;
    m_stable = nstable;
    m_sync1  = m_sync0;
    m_sync0  = in_port;
    m_irq    = |(m_ec & m_mask);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; in_port = 4'hF; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    m_reset();
    ticks(3);
    reset_n = 1'b1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    do_read(3'd0, v);
    total++; if (v !== 32'hF) begin bad++; $display("FAIL reset_data got=%h exp=%h", v, 32'hF); end
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h exp=0", v); end
    do_read(3'd4, v);
    total++; if (v !== 32'hF) begin bad++; $display("FAIL reset_fall_en got=%h exp=%h", v, 32'hF); end
    do_read(3'd5, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_rise_en got=%h exp=0", v); end
  endtask

  task automatic test_bounce();
    logic [31:0] v;
    for (int r = 0; r < 5; r++) begin
      in_port = 4'hE; ticks(3);
      in_port = 4'hF; ticks(3);
    end
    ticks(6);
    do_read(3'd0, v);
    total++; if (v !== 32'hF) begin bad++; $display("FAIL bounce_data got=%h exp=%h", v, 32'hF); end
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL bounce_edge got=%h exp=0", v); end
  endtask

  task automatic test_press();
    logic [31:0] v;
    int first;
    do_write(3'd2, 32'h4);
    in_port = 4'hB;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (irq === 1'b1 && first == 0) first = n;
    end
    total++; if (first != SYNC + DEB + 1) begin bad++; $display("FAIL press_latency got=%0d exp=%0d", first, SYNC + DEB + 1); end
    do_read(3'd3, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL press_edge got=%h exp=%h", v, 32'h4); end
    do_write(3'd3, 32'h4);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_irq_clear got=%b exp=0", irq); end
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL press_edge_clear got=%h exp=0", v); end
    in_port = 4'hF; ticks(10);
  endtask

  task automatic test_rise();
    logic [31:0] v;
    do_write(3'd5, 32'h1);
    do_write(3'd4, 32'h0);
    in_port = 4'hE; ticks(10);
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rise_press_edge got=%h exp=0", v); end
    do_read(3'd0, v);
    total++; if (v !== 32'hE) begin bad++; $display("FAIL rise_press_data got=%h exp=%h", v, 32'hE); end
    in_port = 4'hF; ticks(10);
    do_read(3'd3, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL rise_release_edge got=%h exp=%h", v, 32'h1); end
    do_write(3'd3, 32'hF);
    do_write(3'd4, 32'hF);
    do_write(3'd5, 32'h0);
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rise_cleanup got=%h exp=0", v); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    in_port = 4'hD;
    ticks(SYNC + DEB);
    do_write(3'd3, 32'h2);
    do_read(3'd3, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL collision_set_wins got=%h exp=%h", v, 32'h2); end
    in_port = 4'hC; ticks(10);
    do_read(3'd3, v);
    total++; if (v !== 32'h3) begin bad++; $display("FAIL collision_both got=%h exp=%h", v, 32'h3); end
    do_write(3'd3, 32'h1);
    do_read(3'd3, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL collision_w1c_bit0 got=%h exp=%h", v, 32'h2); end
    do_write(3'd3, 32'hF);
    in_port = 4'hF; ticks(10);
    do_read(3'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL collision_cleanup got=%h exp=0", v); end
  endtask

  task automatic test_async_reset();
    int first;
    in_port = 4'h7;
    ticks(4);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL areset_readdata got=%h exp=0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL areset_irq got=%b exp=0", irq); end
    ticks(3);
    reset_n = 1'b1;
    address = 3'd3;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL areset_edge_after got=%h exp=0", readdata); end
      end
      if (readdata[3] === 1'b1 && first == 0) first = n;
    end
    // Capture registers 7 cycles after release; the registered read shows it one cycle later.
    total++; if (first != SYNC + DEB + 2) begin bad++; $display("FAIL areset_latency got=%0d exp=%0d", first, SYNC + DEB + 2); end
    total++; if (readdata !== 32'h8) begin bad++; $display("FAIL areset_edge got=%h exp=%h", readdata, 32'h8); end
  endtask

  task automatic test_random();
    int hold;
    int r;
    hold = 0;
    do_write(3'd2, 32'hF);
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      r = $urandom_range(0, 9);
      address = 3'($urandom);
      chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
      if (r < 3) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else if (r == 3) begin
        write_n = 1'b0;
      end else if (r == 4) begin
        chipselect = 1'b1;
      end
      tick();
      total++; if (readdata !== m_rd) begin bad++; $display("FAIL rand_readdata cyc=%0d got=%h exp=%h", c, readdata, m_rd); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, irq, m_irq); end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_rise();
    test_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/avalon_debounced_button_pio.md
Name: avalon_debounced_button_pio

Overview:
Parametrised Avalon-MM input PIO for push-buttons and switches, and the next generation of the 4-bit button PIO.
- Per bit: configurable synchroniser depth, counter-based debounce, and independently enabled rising and falling edge capture.
- Write-1-to-clear edge capture and a masked level interrupt to the CPU.
- Sits between the board button pins and the Qsys interconnect as an s1 slave with an irq sender.

Parameters:
WIDTH, 4, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (>=2)
DEBOUNCE_CYCLES, 50000, consecutive cycles an input must differ from the stable value before it is accepted (>=1)
IDLE_LEVEL, {WIDTH{1'b1}}, reset value of synchroniser and stable registers (buttons idle high)

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  level interrupt
in_port  in  WIDTH  asynchronous button/switch inputs

Behaviour:
- Clock and reset: one clock (clk); reset (reset_n) is asynchronous and active-low. All flops are async-reset.
- Reset values:
  - readdata=0, irq=0, irq_mask=0, edge_capture=0, rise_en=0, fall_en=all-ones.
  - Synchroniser and stable registers = IDLE_LEVEL; debounce counters = 0.
  - No edge is captured out of reset.
- Register map (bits above WIDTH read 0, writes to them are ignored):
  - 0 data: debounced stable value, RO.
  - 1 raw: synchronised pre-debounce value, RO.
  - 2 irq_mask: RW.
  - 3 edge_capture: read returns the bits; a write clears exactly the bits where writedata=1 (W1C).
  - 4 fall_en: RW.
  - 5 rise_en: RW.
  - 6, 7: read 0, writes ignored.
- Write: occurs when chipselect && !write_n. The register updates on that clock edge.
- Read:
  - readdata <= zero-extended mux(address) every clock, regardless of chipselect; read latency is 1 cycle.
  - readdata reflects register contents before any write in the same cycle.
- Synchroniser: SYNC_STAGES flops per bit; raw = last stage.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES)+1:
  - raw==stable: counter <= 0.
  - raw!=stable and counter==DEBOUNCE_CYCLES-1: stable <= raw, counter <= 0.
  - Otherwise: counter increments.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles, reverting at any point, leaves stable unchanged and resets the count.
  - DEBOUNCE_CYCLES=1 means stable follows raw with 1 cycle delay.
- Edge detect:
  - stable_d <= stable.
  - rise = stable & ~stable_d & rise_en.
  - fall = ~stable & stable_d & fall_en.
  - edge_capture bit sets on the clock after stable changes.
  - rise_en/fall_en are applied at detect time; changing them does not alter already-captured bits.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins (the event is never lost). Other bits are cleared normally.
- Writes to rise_en/fall_en/irq_mask take effect on the next cycle's detect/irq.
- irq = |(edge_capture & irq_mask), combinational from registers, so it is asserted the same cycle the capture bit or mask bit is registered.
- Total latency from an in_port step to the edge_capture bit: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Reset asserted mid-debounce or mid-transaction: everything returns to reset values immediately. After release, a held non-IDLE input is debounced afresh and produces an edge if enabled.

Test Plan:
- Reset state (WIDTH=4, SYNC=2, DEB=4, in_port=4'hF) -> read addr 0 = 0xF, addr 3 = 0, addr 4 = 0xF, addr 5 = 0, irq=0.
- Bounce rejection: bit0 low for 3 cycles then high, repeated 5 times -> addr 0 stays 0xF, edge_capture=0.
- Clean press: bit2 low and held, irq_mask=4'h4 -> edge_capture=4'h4 exactly 2+4+1=7 cycles after the step; irq=1. Write 0x4 to addr 3 -> edge_capture=0, irq=0.
- Rise mode: rise_en=4'h1, fall_en=0; pulse bit0 low for 10 cycles then high -> only the release sets edge_capture[0]; the press captures nothing.
- Collision: a W1C of 0x2 to addr 3 lands in the same cycle a new falling edge on bit1 is detected -> edge_capture[1] stays 1. A separate W1C of 0x1 with bits 0 and 1 set -> only bit0 cleared.
- Async reset mid-count: hold bit3 low, assert reset_n after 2 debounce cycles, release -> addr 3 reads 0 immediately after reset. edge_capture[3] sets 7 cycles after release, with in_port still low.
